tohost_mailbox: RTL and testbench
=================================

// Module: tohost_mailbox
// PURPOSE
//  Memory-mapped test-host responder on the core data bus. The core writes its
//  end-of-test code and signature words here. The block raises done/pass flags
//  and buffers the signature in a FIFO for the bench or an external host to drain.
//  It also keeps cycle and retired-instruction counters.
//  Sits beside the DTCM behind the data-bus address decoder.
// PARAMETERS
//  ADDR_W     5      byte-address width of the register window (offsets 0x00-0x1F)
//  SIG_DEPTH  16     signature FIFO depth in 32-bit words (power of 2, >=2)
//  TIMEOUT    32'd50000  watchdog limit in cycles (used only with TOHOST_TIMEOUT_EN)
// PORTS
//  clk          in   1       core clock
//  cpurst_n     in   1       asynchronous, active-low reset
//  req_valid    in   1       bus request valid
//  req_ready    out  1       bus request ready
//  req_write    in   1       1=write, 0=read
//  req_addr     in   ADDR_W  byte offset; [1:0] ignored
//  req_wdata    in   32      write data
//  req_wstrb    in   4       byte strobes
//  rsp_valid    out  1       response valid (read data / write ack)
//  rsp_ready    in   1       response accepted
//  rsp_rdata    out  32      read data; 0 for writes
//  inst_retire  in   1       one instruction retired this cycle (de2ex valid)
//  sig_pop      in   1       pop one signature word
//  sig_data     out  32      FIFO head word; 0 when empty
//  sig_empty    out  1       FIFO empty
//  test_done    out  1       sticky: end of test reached
//  test_pass    out  1       sticky: tohost value was 1
//  exit_code    out  31      tohost value >> 1 (RISC-V tohost convention)
// BEHAVIOUR
//  Reset values:
//   req_ready=1, rsp_valid=0, rsp_rdata=0, sig_empty=1, sig_data=0.
//   test_done=0, test_pass=0, exit_code=0. Counters, FIFO and overflow cleared.
//  Reset mid-operation:
//   Reset aborts any pending response and discards FIFO contents.
//  Handshake:
//   Request accepted on req_valid & req_ready.
//   req_ready = ~rsp_valid | rsp_ready, so at most one response is outstanding.
//   rsp_valid rises the cycle after accept and holds, with rdata stable, until rsp_ready.
//   Back-to-back accesses therefore sustain 1 access per cycle.
//  Register map (word offsets):
//   0x00 TOHOST   W: full-word write (wstrb=4'hF) with wdata[0]=1 and test_done=0
//                 sets test_done=1, test_pass=(wdata==1), exit_code=wdata[31:1].
//                 Writes are ignored if wdata[0]=0, the write is partial, or the test
//                 is already done (first write wins).
//                 R: last effective TOHOST value, else 0.
//   0x04 SIGPUSH  W: push wdata; if the FIFO is full, drop the word and set sticky
//                 overflow. Partial strobes push wdata masked bytewise (unstrobed bytes=0).
//                 R: 0.
//   0x08 STATUS   R: {16'b0, count[7:0], 4'b0, timeout, overflow, test_pass, test_done}.
//   0x0C CYCLE    R: cycle counter. Counts +1 per cycle while !test_done, wraps at 2^32,
//                 then freezes at done.
//   0x10 INSTRET  R: +1 per inst_retire while !test_done, wraps at 2^32, then freezes.
//   Other offsets: reads return 0, writes are ignored; a response is still always given.
//   Writes to 0x08-0x10 are ignored.
//  FIFO:
//   A pop while empty is ignored.
//   Simultaneous push and pop when full: both succeed, count is unchanged, no overflow.
//   Simultaneous push and pop when empty: the push lands and the pop is ignored.
//   sig_data is the registered head word, valid while !sig_empty.
//  Done state:
//   Once done, the counters freeze. The FIFO remains pushable and poppable.
// CONFIGURATION
//  TOHOST_TIMEOUT_EN defined:
//   A watchdog counts cycles while !test_done.
//   When the count reaches TIMEOUT: test_done=1, test_pass=0, exit_code=31'h7FFF_FFFF,
//   STATUS.timeout=1.
//   A TOHOST write in the same cycle takes priority over the timeout.
//  Not defined:
//   No watchdog logic; STATUS.timeout reads 0; test_done is set only by TOHOST.
// TESTING
//  1 Write TOHOST=32'h1 -> next cycle test_done=1, test_pass=1, exit_code=0;
//    CYCLE reads the same value twice, 10 cycles apart.
//  2 Write TOHOST=32'h7, then TOHOST=32'h1 -> test_pass=0, exit_code=3;
//    the second write is ignored and TOHOST reads 32'h7.
//  3 Push 17 words 0x100..0x110 with SIG_DEPTH=16 -> STATUS count=16, overflow=1;
//    16 pops yield 0x100..0x10F, then sig_empty=1.
//  4 With the FIFO full, assert push and sig_pop in the same cycle -> count stays 16,
//    overflow stays 0, and the new word lands at the tail.
//  5 Hold rsp_ready=0 for 3 cycles after a read of INSTRET (inst_retire pulsed 5 times)
//    -> rsp_valid held, rdata=5, req_ready=0 until release.
//  6 TOHOST_TIMEOUT_EN, TIMEOUT=100, no TOHOST write -> at cycle 100 test_done=1,
//    test_pass=0, STATUS=32'h0000_0009. Assert cpurst_n low mid-run -> all flags
//    clear and sig_empty=1.

Source files
------------

// File: rtl/tohost_mailbox.sv
// tohost_mailbox: test-host responder (tohost flags, signature FIFO, cycle/instret).
// Ports: clk, cpurst_n; req_*/rsp_* bus handshake; inst_retire; sig_pop/sig_data/sig_empty;
// test_done, test_pass, exit_code. Optional watchdog: define TOHOST_TIMEOUT_EN.
module tohost_mailbox #(
  parameter int          ADDR_W    = 5,
  parameter int          SIG_DEPTH = 16,
  parameter logic [31:0] TIMEOUT   = 32'd50000
) (
  input  logic              clk,
  input  logic              cpurst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  input  logic              inst_retire,
  input  logic              sig_pop,
  output logic [31:0]       sig_data,
  output logic              sig_empty,
  output logic              test_done,
  output logic              test_pass,
  output logic [30:0]       exit_code
);

  localparam int AW = ADDR_W - 2;
  localparam int PW = $clog2(SIG_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [AW-1:0] OFF_TOHOST  = AW'(0);
  localparam logic [AW-1:0] OFF_SIGPUSH = AW'(1);
  localparam logic [AW-1:0] OFF_STATUS  = AW'(2);
  localparam logic [AW-1:0] OFF_CYCLE   = AW'(3);
  localparam logic [AW-1:0] OFF_INSTRET = AW'(4);

  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic [31:0]   tohost_q, tohost_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [30:0]   exit_q, exit_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   cycle_q, cycle_d;
  logic [31:0]   instret_q, instret_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   mem_q [SIG_DEPTH];

  logic [AW-1:0] word;
  logic          unused_addr;
  logic          accept, wr;
  logic          sel_tohost, sel_sigpush, sel_status;
  logic          sel_cycle, sel_instret;
  logic          full, empty, push, pop, push_ok;
  logic          tohost_wr;
  logic          timeout_flag;
  logic [31:0]   wmask, status, rd_data;

  assign word        = req_addr[ADDR_W-1:2];
  assign unused_addr = ^req_addr[1:0];

  assign sel_tohost  = (word == OFF_TOHOST);
  assign sel_sigpush = (word == OFF_SIGPUSH);
  assign sel_status  = (word == OFF_STATUS);
  assign sel_cycle   = (word == OFF_CYCLE);
  assign sel_instret = (word == OFF_INSTRET);

  assign req_ready = ~rsp_valid_q | rsp_ready;
  assign accept    = req_valid & req_ready;
  assign wr        = accept & req_write;

  assign full  = (count_q == CW'(SIG_DEPTH));
  assign empty = (count_q == '0);
  assign push  = wr & sel_sigpush;
  assign pop   = sig_pop & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push & (~full | pop);

  assign wmask = {{8{req_wstrb[3]}}, {8{req_wstrb[2]}},
                  {8{req_wstrb[1]}}, {8{req_wstrb[0]}}};

  assign tohost_wr = wr & sel_tohost & (req_wstrb == 4'hF)
                   & req_wdata[0] & ~done_q;

  assign status = {16'b0, 8'(count_q), 4'b0,
                   timeout_flag, overflow_q, pass_q, done_q};

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      sel_tohost:  rd_data = tohost_q;
      sel_status:  rd_data = status;
      sel_cycle:   rd_data = cycle_q;
      sel_instret: rd_data = instret_q;
      default:     rd_data = '0;
    endcase
  end

`ifdef TOHOST_TIMEOUT_EN
  logic timeout_q, timeout_d;
  logic timeout_hit;

  // The cycle counter runs exactly while !test_done, so it doubles as the watchdog.
  assign timeout_hit  = ~done_q & (cycle_q == TIMEOUT - 32'd1);
  assign timeout_flag = timeout_q;

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) timeout_q <= 1'b0;
    else           timeout_q <= timeout_d;
  end
`else
  localparam logic [31:0] UNUSED_TIMEOUT = TIMEOUT;
  logic timeout_hit;

  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    rsp_valid_d = accept | (rsp_valid_q & ~rsp_ready);
    rsp_rdata_d = rsp_rdata_q;
    if (accept) rsp_rdata_d = req_write ? '0 : rd_data;

    tohost_d = tohost_q;
    done_d   = done_q;
    pass_d   = pass_q;
    exit_d   = exit_q;
`ifdef TOHOST_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    if (tohost_wr) begin
      tohost_d = req_wdata;
      done_d   = 1'b1;
      pass_d   = (req_wdata == 32'd1);
      exit_d   = req_wdata[31:1];
    end else if (timeout_hit) begin
      done_d = 1'b1;
      pass_d = 1'b0;
      exit_d = 31'h7FFF_FFFF;
`ifdef TOHOST_TIMEOUT_EN
      timeout_d = 1'b1;
`endif
    end

    cycle_d   = done_q ? cycle_q : cycle_q + 32'd1;
    instret_d = instret_q + {31'b0, inst_retire & ~done_q};

    overflow_d = overflow_q | (push & full & ~pop);
    wr_ptr_d   = wr_ptr_q + PW'(push_ok);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(push_ok) - CW'(pop);
  end

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      tohost_q    <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      exit_q      <= '0;
      overflow_q  <= 1'b0;
      cycle_q     <= '0;
      instret_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      tohost_q    <= tohost_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      exit_q      <= exit_d;
      overflow_q  <= overflow_d;
      cycle_q     <= cycle_d;
      instret_q   <= instret_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: sig_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= req_wdata & wmask;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign sig_empty = empty;
  assign sig_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign test_done = done_q;
  assign test_pass = pass_q;
  assign exit_code = exit_q;

endmodule

// File: tb/tb_tohost_mailbox.sv
// tb_tohost_mailbox: directed bench for tohost_mailbox with a response scoreboard.
// Build with TOHOST_TIMEOUT_EN to exercise the watchdog path.
module tb_tohost_mailbox;

  logic        clk = 1'b0;
  logic        cpurst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        inst_retire;
  logic        sig_pop;
  logic [31:0] sig_data;
  logic        sig_empty;
  logic        test_done;
  logic        test_pass;
  logic [30:0] exit_code;

  int          checks;
  int          failures;
  logic [31:0] expq[$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  tohost_mailbox #(
    .ADDR_W   (5),
    .SIG_DEPTH(16),
    .TIMEOUT  (32'd100)
  ) dut (
    .clk        (clk),
    .cpurst_n   (cpurst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .inst_retire(inst_retire),
    .sig_pop    (sig_pop),
    .sig_data   (sig_data),
    .sig_empty  (sig_empty),
    .test_done  (test_done),
    .test_pass  (test_pass),
    .exit_code  (exit_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [4:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] exp, input string tag,
                     input logic pop = 1'b0);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    sig_pop   = pop;
    n = 0;
    while (!req_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n == 16) chk({tag, "_accept"}, 32'(req_ready), 32'd1);
    expq.push_back(exp);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    sig_pop   = 1'b0;
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk(tag, rsp_rdata, expq.pop_front());
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d,
                    input logic [3:0] s, input string tag);
    bus(1'b1, a, d, s, 32'd0, tag);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp,
                    input string tag);
    bus(1'b0, a, 32'd0, 4'h0, exp, tag);
  endtask

  task automatic pop_expect(input logic [31:0] exp, input string tag);
    @(negedge clk);
    chk({tag, "_nonempty"}, 32'(sig_empty), 32'd0);
    chk(tag, sig_data, exp);
    sig_pop = 1'b1;
    @(posedge clk);
    #1 sig_pop = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid   = 1'b0;
    sig_pop     = 1'b0;
    inst_retire = 1'b0;
    rsp_ready   = 1'b1;
    cpurst_n    = 1'b0;
    repeat (2) @(negedge clk);
    cpurst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    cpurst_n    = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_wstrb   = '0;
    rsp_ready   = 1'b1;
    inst_retire = 1'b0;
    sig_pop     = 1'b0;
    #2 cpurst_n = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_sig_empty", 32'(sig_empty), 32'd1);
    chk("rst_sig_data", sig_data, 32'd0);
    chk("rst_done", 32'(test_done), 32'd0);
    chk("rst_pass", 32'(test_pass), 32'd0);
    chk("rst_exit", 32'(exit_code), 32'd0);
    cpurst_n = 1'b1;

    // Response backpressure on an INSTRET read
    inst_retire = 1'b1;
    repeat (5) @(negedge clk);
    inst_retire = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 5'h10;
    expq.push_back(32'd5);
    @(posedge clk);
    #1 req_valid = 1'b0;
    exp_v = expq.pop_front();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_instret", rsp_rdata, exp_v);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1 chk("release_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("release_rsp_valid", 32'(rsp_valid), 32'd0);

    rd(5'h14, 32'd0, "unmapped_rd");
    wr(5'h1C, 32'hDEAD_BEEF, 4'hF, "unmapped_wr");
    rd(5'h1C, 32'd0, "unmapped_rd2");
    rd(5'h04, 32'd0, "sigpush_rd");
    wr(5'h08, 32'hFFFF_FFFF, 4'hF, "status_wr");
    rd(5'h08, 32'd0, "status_after_wr");

    // FIFO overflow and drain order
    do_reset();
    for (int i = 0; i < 17; i++)
      wr(5'h04, 32'h100 + 32'(i), 4'hF, "push");
    rd(5'h08, 32'h0000_1004, "status_ovf");
    for (int i = 0; i < 16; i++)
      pop_expect(32'h100 + 32'(i), "drain");
    @(negedge clk);
    chk("drained_empty", 32'(sig_empty), 32'd1);
    chk("drained_data", sig_data, 32'd0);
    wr(5'h04, 32'hAABB_CCDD, 4'b0101, "push_partial");
    @(negedge clk);
    chk("partial_data", sig_data, 32'h00BB_00DD);

    // Reset with a response outstanding
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 5'h0C;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("pend_rsp_valid", 32'(rsp_valid), 32'd1);
    #2 cpurst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_sig_empty", 32'(sig_empty), 32'd1);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    cpurst_n = 1'b1;
    rd(5'h08, 32'd0, "status_after_abort");

    // Push and pop together when full, then when empty
    do_reset();
    for (int i = 0; i < 16; i++)
      wr(5'h04, 32'h200 + 32'(i), 4'hF, "fill");
    rd(5'h08, 32'h0000_1000, "status_full");
    bus(1'b1, 5'h04, 32'h2FF, 4'hF, 32'd0, "push_pop_full", 1'b1);
    rd(5'h08, 32'h0000_1000, "status_full2");
    for (int i = 1; i < 16; i++)
      pop_expect(32'h200 + 32'(i), "drain_full");
    pop_expect(32'h2FF, "tail_word");
    bus(1'b1, 5'h04, 32'h333, 4'hF, 32'd0, "push_pop_empty", 1'b1);
    @(negedge clk);
    chk("pe_empty", 32'(sig_empty), 32'd0);
    chk("pe_data", sig_data, 32'h333);
    pop_expect(32'h333, "pe_pop");

    // First effective TOHOST write wins
    do_reset();
    wr(5'h00, 32'h0, 4'hF, "tohost_even");
    wr(5'h00, 32'h7, 4'h7, "tohost_partial");
    chk("ignored_done", 32'(test_done), 32'd0);
    rd(5'h00, 32'd0, "tohost_rd0");
    wr(5'h00, 32'h7, 4'hF, "tohost_7");
    chk("t7_done", 32'(test_done), 32'd1);
    chk("t7_pass", 32'(test_pass), 32'd0);
    chk("t7_exit", 32'(exit_code), 32'd3);
    wr(5'h00, 32'h1, 4'hF, "tohost_1_late");
    chk("late_pass", 32'(test_pass), 32'd0);
    chk("late_exit", 32'(exit_code), 32'd3);
    rd(5'h00, 32'h7, "tohost_rd7");

    // Pass path and counter freeze
    do_reset();
    wr(5'h00, 32'h1, 4'hF, "tohost_pass");
    chk("p_done", 32'(test_done), 32'd1);
    chk("p_pass", 32'(test_pass), 32'd1);
    chk("p_exit", 32'(exit_code), 32'd0);
    rd(5'h08, 32'h0000_0003, "status_pass");
    wr(5'h04, 32'h444, 4'hF, "push_after_done");
    rd(5'h08, 32'h0000_0103, "status_push_done");
    rd(5'h0C, 32'd2, "cycle_a");
    repeat (10) @(negedge clk);
    rd(5'h0C, 32'd2, "cycle_b");
    inst_retire = 1'b1;
    repeat (3) @(negedge clk);
    inst_retire = 1'b0;
    rd(5'h10, 32'd0, "instret_frozen");

    // Watchdog window and mid-run reset
    do_reset();
    repeat (99) @(negedge clk);
    chk("pre_timeout_done", 32'(test_done), 32'd0);
    @(negedge clk);
`ifdef TOHOST_TIMEOUT_EN
    chk("to_done", 32'(test_done), 32'd1);
    chk("to_pass", 32'(test_pass), 32'd0);
    chk("to_exit", 32'(exit_code), 32'h7FFF_FFFF);
    rd(5'h08, 32'h0000_0009, "status_timeout");
`else
    repeat (20) @(negedge clk);
    chk("no_wd_done", 32'(test_done), 32'd0);
    rd(5'h08, 32'd0, "status_no_wd");
`endif
    wr(5'h04, 32'h55, 4'hF, "push_pre_rst");
    wr(5'h00, 32'h3, 4'hF, "tohost_pre_rst");
    @(negedge clk);
    #2 cpurst_n = 1'b0;
    #1;
    chk("mid_rst_done", 32'(test_done), 32'd0);
    chk("mid_rst_pass", 32'(test_pass), 32'd0);
    chk("mid_rst_exit", 32'(exit_code), 32'd0);
    chk("mid_rst_empty", 32'(sig_empty), 32'd1);
    @(negedge clk);
    cpurst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
